// File: rtl/alu_cmd_sequencer_pkg.sv
// rtl/alu_cmd_sequencer_pkg.sv - shared opcode and state definitions for the ALU command sequencer
//
// Purpose: opcode constants for the 19 supported MIPS-style ALU operations and
//          the sequencer state encoding. Imported by the sequencer, the opcode
//          validator and any ALU/bench that needs the same encodings.
// Ports:   none (package).

package alu_cmd_sequencer_pkg;

  // ALU opcodes (6-bit function/opcode field).
  localparam logic [5:0] OP_SLL  = 6'h00;
  localparam logic [5:0] OP_SRL  = 6'h02;
  localparam logic [5:0] OP_SRA  = 6'h03;
  localparam logic [5:0] OP_SLLV = 6'h04;
  localparam logic [5:0] OP_SRLV = 6'h06;
  localparam logic [5:0] OP_SRAV = 6'h07;
  localparam logic [5:0] OP_ADDU = 6'h21;
  localparam logic [5:0] OP_SUBU = 6'h23;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_XOR  = 6'h26;
  localparam logic [5:0] OP_NOR  = 6'h27;
  localparam logic [5:0] OP_SLT  = 6'h2A;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_SLTI = 6'h0A;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } seq_state_e;

endpackage

// File: rtl/alu_op_validator.sv
// rtl/alu_op_validator.sv - combinational opcode validity check
//
// Purpose: flags whether an opcode is one of the 19 operations the ALU implements.
// Ports:
//   i_opcode  in  SIZEOP  candidate opcode
//   o_valid   out 1       high when i_opcode is a supported operation

module alu_op_validator
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int SIZEOP = 6
) (
  input  logic [SIZEOP-1:0] i_opcode,
  output logic              o_valid
);

  always_comb begin
    o_valid = 1'b0;
    case (i_opcode)
      SIZEOP'(OP_SLL),  SIZEOP'(OP_SRL),  SIZEOP'(OP_SRA),
      SIZEOP'(OP_SLLV), SIZEOP'(OP_SRLV), SIZEOP'(OP_SRAV),
      SIZEOP'(OP_ADDU), SIZEOP'(OP_SUBU), SIZEOP'(OP_AND),
      SIZEOP'(OP_OR),   SIZEOP'(OP_XOR),  SIZEOP'(OP_NOR),
      SIZEOP'(OP_SLT),  SIZEOP'(OP_ADDI), SIZEOP'(OP_ANDI),
      SIZEOP'(OP_ORI),  SIZEOP'(OP_XORI), SIZEOP'(OP_LUI),
      SIZEOP'(OP_SLTI): o_valid = 1'b1;
      default:          o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - byte-stream command sequencer for the 8-bit ALU
//
// Purpose: collects operand A, operand B and opcode bytes from the UART receiver,
//          validates the opcode, drives the external combinational ALU for one
//          cycle, captures the result and hands it to the UART transmitter.
// Ports:
//   i_clock     in  1         system clock, rising edge
//   i_reset_n   in  1         asynchronous active-low reset
//   i_rx_data   in  SIZEDATA  received byte
//   i_rx_done   in  1         strobe, i_rx_data valid
//   o_datoa     out SIZEDATA  ALU operand A (registered)
//   o_datob     out SIZEDATA  ALU operand B (registered)
//   o_opcode    out SIZEOP    ALU opcode (registered)
//   i_result    in  SIZEDATA  ALU combinational result
//   o_tx_data   out SIZEDATA  byte to transmit (captured result)
//   o_tx_start  out 1         one-cycle strobe to transmitter
//   i_tx_done   in  1         strobe, transmit finished
//   o_busy      out 1         high whenever not idle
//   o_error     out 1         sticky invalid-opcode flag
//   o_timeout   out 1         one-cycle pulse on command abort
//   o_overrun   out 1         one-cycle pulse when a byte is dropped

module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int SIZEDATA = 8,
  parameter int SIZEOP   = 6,
  parameter int TIMEOUT  = 1000,
  parameter int TOUT_W   = 10
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [SIZEDATA-1:0] i_rx_data,
  input  logic                i_rx_done,
  output logic [SIZEDATA-1:0] o_datoa,
  output logic [SIZEDATA-1:0] o_datob,
  output logic [SIZEOP-1:0]   o_opcode,
  input  logic [SIZEDATA-1:0] i_result,
  output logic [SIZEDATA-1:0] o_tx_data,
  output logic                o_tx_start,
  input  logic                i_tx_done,
  output logic                o_busy,
  output logic                o_error,
  output logic                o_timeout,
  output logic                o_overrun
);

  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT - 1);
  localparam logic [TOUT_W-1:0] TOUT_MAX  = {TOUT_W{1'b1}};

  seq_state_e          state_q, state_d;
  logic [SIZEDATA-1:0] data_a_q, data_a_d;
  logic [SIZEDATA-1:0] data_b_q, data_b_d;
  logic [SIZEOP-1:0]   opcode_q, opcode_d;
  logic [SIZEDATA-1:0] result_q, result_d;
  logic                error_q, error_d;
  logic [TOUT_W-1:0]   cnt_q, cnt_d;

  logic                op_valid;
  logic [TOUT_W-1:0]   cnt_inc;
  logic                tout_hit;
  logic                tx_start;
  logic                timeout;
  logic                overrun;

  // Checks the incoming byte directly so the decision is made in the strobe cycle.
  alu_op_validator #(
    .SIZEOP (SIZEOP)
  ) u_op_validator (
    .i_opcode (i_rx_data[SIZEOP-1:0]),
    .o_valid  (op_valid)
  );

  // Saturating increment; the abort fires in the cycle the count would reach
  // TIMEOUT-1, so the comparison is on the incremented value.
  assign cnt_inc  = (cnt_q == TOUT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign tout_hit = (cnt_inc >= TOUT_LAST);

  always_comb begin
    state_d  = state_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    opcode_d = opcode_q;
    result_d = result_q;
    error_d  = error_q;
    cnt_d    = '0;
    tx_start = 1'b0;
    timeout  = 1'b0;
    overrun  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_done) begin
          data_a_d = i_rx_data;
          error_d  = 1'b0;
          state_d  = ST_WAIT_B;
        end
      end

      ST_WAIT_B: begin
        // A byte on the abort cycle takes priority over the timeout.
        if (i_rx_done) begin
          data_b_d = i_rx_data;
          state_d  = ST_WAIT_OP;
        end else if (tout_hit) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_WAIT_OP: begin
        if (i_rx_done) begin
          opcode_d = i_rx_data[SIZEOP-1:0];
          if (op_valid) begin
            state_d = ST_EXEC;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (tout_hit) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_EXEC: begin
        // Operands and opcode are already registered, so i_result is settled here.
        result_d = i_result;
        overrun  = i_rx_done;
        state_d  = ST_SEND;
      end

      ST_SEND: begin
        tx_start = 1'b1;
        overrun  = i_rx_done;
        state_d  = ST_WAIT_TX;
      end

      ST_WAIT_TX: begin
        overrun = i_rx_done;
        if (i_tx_done) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      data_a_q <= '0;
      data_b_q <= '0;
      opcode_q <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_datoa    = data_a_q;
  assign o_datob    = data_b_q;
  assign o_opcode   = opcode_q;
  assign o_tx_data  = result_q;
  assign o_tx_start = tx_start;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_error    = error_q;
  assign o_timeout  = timeout;
  assign o_overrun  = overrun;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed table-driven bench for alu_cmd_sequencer

module tb_alu_cmd_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] datoa;
  logic [7:0] datob;
  logic [5:0] opcode;
  logic [7:0] alu_res;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic       busy;
  logic       error;
  logic       timeout;
  logic       overrun;

  int checks;
  int failures;

  alu_cmd_sequencer #(
    .SIZEDATA (8),
    .SIZEOP   (6),
    .TIMEOUT  (16),
    .TOUT_W   (5)
  ) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_done  (rx_done),
    .o_datoa    (datoa),
    .o_datob    (datob),
    .o_opcode   (opcode),
    .i_result   (alu_res),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .i_tx_done  (tx_done),
    .o_busy     (busy),
    .o_error    (error),
    .o_timeout  (timeout),
    .o_overrun  (overrun)
  );

  // Reduced ALU attached to the sequencer (subset of operations used below).
  always_comb begin
    alu_res = 8'h00;
    case (opcode)
      6'h02: alu_res = datoa >> datob;
      6'h03: alu_res = 8'($signed(datoa) >>> datob);
      6'h21: alu_res = datoa + datob;
      6'h23: alu_res = datoa - datob;
      6'h24: alu_res = datoa & datob;
      6'h25: alu_res = datoa | datob;
      default: alu_res = 8'h00;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Opcode strobe through transmit completion; optionally drops a byte in WAIT_TX.
  task automatic finish_from_op(input logic [7:0] op, input logic [7:0] exp, input bit inject_ovr);
    rx_data = op;
    rx_done = 1'b1;
    #1;
    chk("op_cycle_tx_start", tx_start, 0);
    tick();
    rx_done = 1'b0;
    #1;
    chk("exec_tx_start", tx_start, 0);
    tick();
    #1;
    chk("send_tx_start", tx_start, 1);
    chk("send_tx_data", tx_data, exp);
    tick();
    if (inject_ovr) begin
      rx_data = 8'h99;
      rx_done = 1'b1;
      #1;
      chk("ovr_pulse", overrun, 1);
      chk("ovr_tx_data", tx_data, exp);
      tick();
      rx_done = 1'b0;
      #1;
      chk("ovr_still_busy", busy, 1);
      chk("ovr_pulse_end", overrun, 0);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    #1;
    chk("done_busy", busy, 0);
    chk("done_tx_data", tx_data, exp);
  endtask

  task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input logic [7:0] exp, input bit inject_ovr);
    send_byte(a);
    send_byte(b);
    finish_from_op(op, exp, inject_ovr);
  endtask

  initial begin
    bit seen;
    checks   = 0;
    failures = 0;

    vecs[0] = '{a: 8'h05, b: 8'h03, op: 8'h21, exp: 8'h08};
    vecs[1] = '{a: 8'h05, b: 8'h07, op: 8'h23, exp: 8'hFE};
    vecs[2] = '{a: 8'h80, b: 8'h03, op: 8'h03, exp: 8'hF0};
    vecs[3] = '{a: 8'h80, b: 8'h03, op: 8'h02, exp: 8'h10};
    vecs[4] = '{a: 8'h05, b: 8'h03, op: 8'hE1, exp: 8'h08};
    vecs[5] = '{a: 8'h0F, b: 8'hF0, op: 8'h25, exp: 8'hFF};
    vecs[6] = '{a: 8'h0C, b: 8'h0A, op: 8'h24, exp: 8'h08};

    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_datoa", datoa, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_error", error, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Stray tx_done while idle does nothing.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    #1;
    chk("idle_tx_done_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      do_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 1'b0);
      chk("vec_opcode", opcode, 32'(vecs[i].op[5:0]));
      tick();
    end

    // Invalid opcode: error set, back to idle, nothing transmitted.
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h3F);
    #1;
    chk("inv_error", error, 1);
    chk("inv_busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (tx_start) seen = 1'b1;
      tick();
    end
    chk("inv_no_tx_start", seen, 0);

    // Next accepted byte clears the error; then let the command time out.
    send_byte(8'h01);
    chk("clr_error", error, 0);
    chk("clr_datoa", datoa, 8'h01);
    seen = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      #1;
      if (timeout) seen = 1'b1;
      tick();
    end
    chk("tout_not_early", seen, 0);
    #1;
    chk("tout_pulse", timeout, 1);
    tick();
    #1;
    chk("tout_busy", busy, 0);
    chk("tout_pulse_end", timeout, 0);
    chk("tout_datoa_kept", datoa, 8'h01);

    // Byte arriving on the abort cycle wins.
    send_byte(8'hAA);
    for (int i = 1; i <= 14; i++) tick();
    rx_data = 8'h55;
    rx_done = 1'b1;
    #1;
    chk("race_no_timeout", timeout, 0);
    tick();
    rx_done = 1'b0;
    #1;
    chk("race_busy", busy, 1);
    chk("race_datob", datob, 8'h55);
    finish_from_op(8'h21, 8'hFF, 1'b0);

    // Overrun while waiting for the transmitter, then a clean command.
    do_cmd(8'h05, 8'h03, 8'h21, 8'h08, 1'b1);
    do_cmd(8'h05, 8'h07, 8'h23, 8'hFE, 1'b0);

    // Async reset in WAIT_OP.
    send_byte(8'h05);
    send_byte(8'h03);
    rst_n = 1'b0;
    #1;
    chk("rst_wop_busy", busy, 0);
    chk("rst_wop_datoa", datoa, 0);
    chk("rst_wop_datob", datob, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Async reset in SEND.
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h21);
    tick();
    #1;
    chk("pre_rst_send", tx_start, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_send_tx_start", tx_start, 0);
    chk("rst_send_tx_data", tx_data, 0);
    chk("rst_send_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (tx_start) seen = 1'b1;
      tick();
    end
    chk("rst_no_tx_start", seen, 0);

    do_cmd(8'h01, 8'h01, 8'h21, 8'h02, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
